// File: rtl/ct_lsu_dcache_tag_ctrl_pkg.sv
// Shared LSU dcache tag definitions: array geometry and the access-controller FSM encoding.
package ct_lsu_dcache_tag_ctrl_pkg;

  localparam int TAG_W     = 52;
  localparam int WAY_W     = 26;
  localparam int WAY_NUM   = 2;
  localparam int TAG_IDX_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } tag_state_e;

endpackage

// File: rtl/ct_lsu_dcache_tag_ctrl_if.sv
// Requester-side bundle of the dcache tag controller: invalidate, write and read ports.
interface ct_lsu_dcache_tag_ctrl_if
  import ct_lsu_dcache_tag_ctrl_pkg::*;
#(
  parameter int IDX_W = 9
);
  logic               inv_all_req;
  logic               inv_busy;
  logic               inv_all_done;
  logic               wr_vld;
  logic [IDX_W-1:0]   wr_idx;
  logic [WAY_NUM-1:0] wr_way;
  logic [TAG_W-1:0]   wr_din;
  logic               wr_grnt;
  logic               rd_vld;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_grnt;
  logic               rd_data_vld;
  logic [TAG_W-1:0]   rd_data;

  modport master (
    output inv_all_req, wr_vld, wr_idx, wr_way, wr_din, rd_vld, rd_idx,
    input  inv_busy, inv_all_done, wr_grnt, rd_grnt, rd_data_vld, rd_data
  );

  modport slave (
    input  inv_all_req, wr_vld, wr_idx, wr_way, wr_din, rd_vld, rd_idx,
    output inv_busy, inv_all_done, wr_grnt, rd_grnt, rd_data_vld, rd_data
  );
endinterface

// File: rtl/ct_lsu_dcache_tag_ctrl.sv
// Dcache tag SRAM access controller: invalidate sweep > write > read arbitration,
// active-low array controls and a one-cycle registered read-valid.
module ct_lsu_dcache_tag_ctrl
  import ct_lsu_dcache_tag_ctrl_pkg::*;
#(
  parameter int IDX_W       = 9,
  parameter bit INIT_ON_RST = 1'b1
)(
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   cp0_lsu_icg_en,
  ct_lsu_dcache_tag_ctrl_if.slave lsu,
  output logic [TAG_IDX_W-1:0]   tag_idx,
  output logic [TAG_W-1:0]       tag_din,
  output logic                   tag_sel_b,
  output logic                   tag_gwen_b,
  output logic [WAY_NUM-1:0]     tag_wen_b,
  output logic                   tag_gateclk_en,
  input  logic [TAG_W-1:0]       tag_dout
);

  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

  tag_state_e       state_reg, state_next;
  logic [IDX_W-1:0] sweep_cnt_reg, sweep_cnt_next;
  logic             init_pend_reg, init_pend_next;
  logic             rd_data_vld_reg;
  logic             icg_en_unused;

  // The ICG enable belongs to the array wrapper's clock gate; nothing here consumes it.
  assign icg_en_unused = cp0_lsu_icg_en;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg       <= ST_IDLE;
      sweep_cnt_reg   <= '0;
      init_pend_reg   <= INIT_ON_RST;
      rd_data_vld_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sweep_cnt_reg   <= sweep_cnt_next;
      init_pend_reg   <= init_pend_next;
      rd_data_vld_reg <= lsu.rd_grnt;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    init_pend_next = init_pend_reg;
    case (state_reg)
      ST_IDLE: begin
        if (lsu.inv_all_req || init_pend_reg) begin
          state_next     = ST_SWEEP;
          sweep_cnt_next = '0;
          init_pend_next = 1'b0;
        end
      end
      ST_SWEEP: begin
        // Counter parks on the last index; it is cleared again on the next sweep entry.
        if (sweep_cnt_reg == SWEEP_LAST) begin
          state_next = ST_DONE;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + IDX_W'(1);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_sel_b    = 1'b1;
    tag_gwen_b   = 1'b1;
    tag_wen_b    = '1;
    tag_idx      = '0;
    tag_din      = '0;
    lsu.wr_grnt  = 1'b0;
    lsu.rd_grnt  = 1'b0;
    if (state_reg == ST_SWEEP) begin
      tag_sel_b  = 1'b0;
      tag_gwen_b = 1'b0;
      tag_wen_b  = '0;
      tag_idx    = TAG_IDX_W'(sweep_cnt_reg);
    end else if (lsu.wr_vld) begin
      // A colliding read is refused regardless of index; the requester retries.
      lsu.wr_grnt = 1'b1;
      tag_sel_b   = 1'b0;
      tag_gwen_b  = 1'b0;
      tag_wen_b   = ~lsu.wr_way;
      tag_idx     = TAG_IDX_W'(lsu.wr_idx);
      tag_din     = lsu.wr_din;
    end else if (lsu.rd_vld) begin
      lsu.rd_grnt = 1'b1;
      tag_sel_b   = 1'b0;
      tag_idx     = TAG_IDX_W'(lsu.rd_idx);
    end
  end

  assign tag_gateclk_en   = ~tag_sel_b;
  assign lsu.inv_busy     = (state_reg == ST_SWEEP);
  assign lsu.inv_all_done = (state_reg == ST_DONE);
  assign lsu.rd_data_vld  = rd_data_vld_reg;
  assign lsu.rd_data      = rd_data_vld_reg ? tag_dout : '0;

endmodule

// File: tb/tb_ct_lsu_dcache_tag_ctrl.sv
// Randomised bench for the dcache tag controller with a behavioural SRAM and reference model.
module tb_ct_lsu_dcache_tag_ctrl;

  localparam int IDX_W = 9;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        icg_en;
  logic [8:0]  tag_idx;
  logic [51:0] tag_din;
  logic        tag_sel_b;
  logic        tag_gwen_b;
  logic [1:0]  tag_wen_b;
  logic        tag_gateclk_en;
  logic [51:0] tag_dout;

  int n_checks = 0;
  int n_errors = 0;

  logic [51:0] sram [DEPTH];
  logic [51:0] ref_mem [DEPTH];
  bit          pend_vld;
  logic [51:0] pend_data;

  ct_lsu_dcache_tag_ctrl_if #(.IDX_W(IDX_W)) lsu_if ();

  ct_lsu_dcache_tag_ctrl #(.IDX_W(IDX_W), .INIT_ON_RST(1'b1)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .cp0_lsu_icg_en (icg_en),
    .lsu            (lsu_if),
    .tag_idx        (tag_idx),
    .tag_din        (tag_din),
    .tag_sel_b      (tag_sel_b),
    .tag_gwen_b     (tag_gwen_b),
    .tag_wen_b      (tag_wen_b),
    .tag_gateclk_en (tag_gateclk_en),
    .tag_dout       (tag_dout)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM; scrambled during reset so only a real sweep can clear it.
  always @(posedge clk) begin
    if (!cpurst_b) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 52'({$urandom(), $urandom()});
    end else if (!tag_sel_b) begin
      if (!tag_gwen_b) begin
        for (int w = 0; w < 2; w++)
          if (!tag_wen_b[w]) sram[tag_idx][w*26 +: 26] <= tag_din[w*26 +: 26];
      end else begin
        tag_dout <= sram[tag_idx];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_if.inv_all_req = 1'b0;
    lsu_if.wr_vld = 1'b0; lsu_if.wr_idx = '0; lsu_if.wr_way = '0; lsu_if.wr_din = '0;
    lsu_if.rd_vld = 1'b0; lsu_if.rd_idx = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sel_b"}, 64'(tag_sel_b), 64'd1);
    check({pfx, "_gwen_b"}, 64'(tag_gwen_b), 64'd1);
    check({pfx, "_wen_b"}, 64'(tag_wen_b), 64'd3);
    check({pfx, "_gateclk"}, 64'(tag_gateclk_en), 64'd0);
    check({pfx, "_grants"}, 64'({lsu_if.wr_grnt, lsu_if.rd_grnt}), 64'd0);
    check({pfx, "_busy_done"}, 64'({lsu_if.inv_busy, lsu_if.inv_all_done}), 64'd0);
    check({pfx, "_rd_data_vld"}, 64'(lsu_if.rd_data_vld), 64'd0);
  endtask

  // Entered just after reset release; cycle 1 is IDLE, cycles 2..DEPTH+1 sweep, DEPTH+2 is done.
  task automatic run_sweep_window();
    int n_wr = 0, n_bad = 0, n_busy = 0, n_done = 0, done_cyc = -1, n_gbad = 0;
    for (int c = 1; c <= DEPTH + 30; c++) begin
      bit in_sweep = (c >= 2) && (c <= DEPTH + 1);
      idle_inputs();
      if (in_sweep) begin
        lsu_if.wr_vld = 1'($urandom());
        lsu_if.wr_idx = 9'($urandom());
        lsu_if.wr_way = 2'($urandom());
        lsu_if.wr_din = 52'({$urandom(), $urandom()});
        lsu_if.rd_vld = 1'($urandom());
        lsu_if.rd_idx = 9'($urandom());
      end
      lsu_if.inv_all_req = (c == 102);
      @(negedge clk);
      if (!tag_sel_b && !tag_gwen_b) begin
        n_wr++;
        if (!in_sweep || tag_idx != 9'(c - 2) || tag_din != '0 || tag_wen_b != 2'b00) n_bad++;
      end
      if (lsu_if.inv_busy) begin
        n_busy++;
        if (!in_sweep) n_bad++;
      end
      if (lsu_if.inv_all_done) begin
        n_done++;
        done_cyc = c;
      end
      if (lsu_if.wr_grnt || lsu_if.rd_grnt || lsu_if.rd_data_vld || lsu_if.rd_data != '0) n_gbad++;
      @(posedge clk); #1;
    end
    idle_inputs();
    check("sweep_writes", 64'(n_wr), 64'(DEPTH));
    check("sweep_bad_cycles", 64'(n_bad), 64'd0);
    check("sweep_busy_cycles", 64'(n_busy), 64'(DEPTH));
    check("sweep_done_pulses", 64'(n_done), 64'd1);
    check("sweep_done_cycle", 64'(done_cyc), 64'(DEPTH + 2));
    check("sweep_no_grants", 64'(n_gbad), 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    pend_vld = 1'b0;
  endtask

  // One non-sweep cycle: apply requests, compare against the reference model, advance it.
  task automatic drive(input bit wv, input logic [8:0] wi, input logic [1:0] ww,
                       input logic [51:0] wd, input bit rv, input logic [8:0] ri);
    bit          exp_wg, exp_rg, exp_sel, exp_gwen;
    logic [1:0]  exp_wen;
    logic [8:0]  exp_idx;
    logic [51:0] exp_din;
    lsu_if.inv_all_req = 1'b0;
    lsu_if.wr_vld = wv; lsu_if.wr_idx = wi; lsu_if.wr_way = ww; lsu_if.wr_din = wd;
    lsu_if.rd_vld = rv; lsu_if.rd_idx = ri;
    @(negedge clk);
    exp_wg = wv;
    exp_rg = rv && !wv;
    exp_sel = !(wv || rv);
    exp_gwen = !wv;
    exp_wen = wv ? ~ww : 2'b11;
    exp_idx = wv ? wi : (rv ? ri : 9'd0);
    exp_din = wv ? wd : 52'd0;
    check("wr_grnt", 64'(lsu_if.wr_grnt), 64'(exp_wg));
    check("rd_grnt", 64'(lsu_if.rd_grnt), 64'(exp_rg));
    check("tag_sel_b", 64'(tag_sel_b), 64'(exp_sel));
    check("tag_gwen_b", 64'(tag_gwen_b), 64'(exp_gwen));
    check("tag_wen_b", 64'(tag_wen_b), 64'(exp_wen));
    check("tag_idx", 64'(tag_idx), 64'(exp_idx));
    check("tag_din", 64'(tag_din), 64'(exp_din));
    check("gateclk_en", 64'(tag_gateclk_en), 64'(!exp_sel));
    check("busy_done", 64'({lsu_if.inv_busy, lsu_if.inv_all_done}), 64'd0);
    check("rd_data_vld", 64'(lsu_if.rd_data_vld), 64'(pend_vld));
    check("rd_data", 64'(lsu_if.rd_data), 64'(pend_vld ? pend_data : 52'd0));
    if (wv) begin
      if (ww[0]) ref_mem[wi][25:0]  = wd[25:0];
      if (ww[1]) ref_mem[wi][51:26] = wd[51:26];
    end
    pend_vld  = exp_rg;
    pend_data = ref_mem[ri];
    @(posedge clk); #1;
  endtask

  task automatic random_drives(input int n);
    for (int k = 0; k < n; k++)
      drive(1'($urandom_range(0, 2) == 0), 9'($urandom_range(0, 15)), 2'($urandom()),
            52'({$urandom(), $urandom()}), 1'($urandom()), 9'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [51:0] d;
    cpurst_b = 1'b0;
    icg_en   = 1'b0;
    pend_vld = 1'b0;
    idle_inputs();
    @(negedge clk);
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1'b1;
    icg_en = 1'b1;
    run_sweep_window();

    // Partial-way write, then read-after-write of the same index.
    d = 52'hABCDEF0123456;
    drive(1'b1, 9'h1A5, 2'b10, d, 1'b0, 9'h0);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b1, 9'h1A5);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b0, 9'h0);

    // Collision: write wins, held read granted next cycle.
    drive(1'b1, 9'h010, 2'b11, 52'h123456789ABCD, 1'b1, 9'h1A5);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b1, 9'h1A5);

    // Empty way mask selects the array but changes nothing.
    drive(1'b1, 9'h1A5, 2'b00, 52'hFFFFFFFFFFFFF, 1'b0, 9'h0);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b1, 9'h1A5);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b0, 9'h0);

    random_drives(400);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b0, 9'h0);

    // Requested sweep, aborted by reset at index 300.
    lsu_if.inv_all_req = 1'b1;
    @(posedge clk); #1;
    lsu_if.inv_all_req = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
    end
    #1;
    check("midsweep_idx", 64'(tag_idx), 64'd300);
    check("midsweep_busy", 64'(lsu_if.inv_busy), 64'd1);
    cpurst_b = 1'b0;
    #1;
    check_reset_outputs("midsweep_reset");
    repeat (3) @(posedge clk);
    #1 cpurst_b = 1'b1;
    run_sweep_window();

    random_drives(100);
    drive(1'b0, 9'h0, 2'b00, '0, 1'b0, 9'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
